// File: rtl/bus_arbiter.sv
// Round-robin arbiter and 4-phase sequencer for the shared 8-bit system bus.
// One master is granted at a time; completion or timeout is pulsed back, then priority rotates.
module bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        bus_data,
  output logic              bus_sent,
  input  logic              bus_received,
  output logic [NREQ-1:0]   done,
  output logic              timeout_err,
  output logic              busy
);

  localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SCAN_W = PTR_W + 1;
  localparam int CNT_W  = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    RELEASE
  } state_t;

  state_t            state, state_d;
  logic [PTR_W-1:0]  ptr, ptr_d;
  logic [PTR_W-1:0]  widx, widx_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [NREQ-1:0]   grant_d, done_d;
  logic [7:0]        bus_data_d;
  logic              bus_sent_d, timeout_d, busy_d;

  logic              win_found;
  logic [PTR_W-1:0]  win_idx;
  logic [SCAN_W-1:0] scan;

  // Wrap-around search starting at ptr; the first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, ptr} + SCAN_W'(k);
      if (scan >= SCAN_W'(NREQ)) scan = scan - SCAN_W'(NREQ);
      if (!win_found && req[scan[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[PTR_W-1:0];
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    widx_d     = widx;
    cnt_d      = cnt;
    grant_d    = grant;
    bus_data_d = bus_data;
    bus_sent_d = bus_sent;
    busy_d     = busy;
    done_d     = '0;
    timeout_d  = 1'b0;

    unique case (state)
      IDLE: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          bus_data_d       = req_data[{win_idx, 3'b000} +: 8];
          bus_sent_d       = 1'b1;
          busy_d           = 1'b1;
          widx_d           = win_idx;
          cnt_d            = '0;
          state_d          = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // An acknowledge on the final counted cycle still completes the transfer.
        if (bus_received) begin
          bus_sent_d   = 1'b0;
          done_d[widx] = 1'b1;
          state_d      = RELEASE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          bus_sent_d = 1'b0;
          timeout_d  = 1'b1;
          state_d    = RELEASE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!bus_received) begin
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = (widx == PTR_W'(NREQ - 1)) ? '0 : widx + PTR_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      widx        <= '0;
      cnt         <= '0;
      grant       <= '0;
      bus_data    <= '0;
      bus_sent    <= 1'b0;
      busy        <= 1'b0;
      done        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      widx        <= widx_d;
      cnt         <= cnt_d;
      grant       <= grant_d;
      bus_data    <= bus_data_d;
      bus_sent    <= bus_sent_d;
      busy        <= busy_d;
      done        <= done_d;
      timeout_err <= timeout_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized transfers
// checked cycle by cycle against a transaction-level round-robin model.
module tb_bus_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;
  localparam int OBS_W   = NREQ + 8 + 1 + NREQ + 1 + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   grant;
  logic [7:0]        bus_data;
  logic              bus_sent;
  logic              bus_received;
  logic [NREQ-1:0]   done;
  logic              timeout_err;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;
  int model_ptr = 0;

  bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .grant        (grant),
    .bus_data     (bus_data),
    .bus_sent     (bus_sent),
    .bus_received (bus_received),
    .done         (done),
    .timeout_err  (timeout_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OBS_W-1:0] observed();
    return {grant, bus_data, bus_sent, done, timeout_err, busy};
  endfunction

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (model_ptr + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [8*NREQ-1:0] rand_data();
    logic [8*NREQ-1:0] v;
    for (int b = 0; b < NREQ; b++) v[b*8 +: 8] = 8'($urandom);
    return v;
  endfunction

  // One transfer from IDLE. d = idle cycles before the target acks (d >= TIMEOUT never acks),
  // h = cycles the ack is held. Checks every output on every cycle until release.
  task automatic do_transfer(input string tag, input logic [NREQ-1:0] r,
                             input logic [8*NREQ-1:0] data, input int d, input int h,
                             input bit scramble, output int w);
    logic [NREQ-1:0]  oh;
    logic [7:0]       byte_exp;
    logic [OBS_W-1:0] exp_v;
    bit               ack;
    int               a, hh;
    req          = r;
    req_data     = data;
    bus_received = 1'b0;
    w        = model_pick(r);
    oh       = NREQ'(1) << w;
    byte_exp = data[w*8 +: 8];
    ack      = (d <= TIMEOUT - 1);
    a        = ack ? d + 1 : TIMEOUT;
    hh       = ack ? h : 1;
    step();
    exp_v = {oh, byte_exp, 1'b1, {NREQ{1'b0}}, 1'b0, 1'b1};
    n_tests++;
    if (observed() !== exp_v) begin
      n_fail++;
      $display("FAIL %s grant: got %h expected %h", tag, observed(), exp_v);
    end
    for (int t = 1; t <= a + hh; t++) begin
      bus_received = ack && (t >= a) && (t < a + hh);
      if (scramble) begin
        req      = NREQ'($urandom);
        req_data = rand_data();
      end
      step();
      exp_v = {(t < a + hh) ? oh : {NREQ{1'b0}}, byte_exp, (t < a),
               (ack && t == a) ? oh : {NREQ{1'b0}}, (!ack && t == a), (t < a + hh)};
      n_tests++;
      if (observed() !== exp_v) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", tag, t, observed(), exp_v);
      end
    end
    bus_received = 1'b0;
    req          = '0;
    model_ptr    = (w + 1) % NREQ;
  endtask

  task automatic apply_reset();
    reset        = 1'b1;
    req          = '0;
    req_data     = '0;
    bus_received = 1'b0;
    step();
    step();
    reset     = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (observed() !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0", observed());
    end
  endtask

  task automatic test_basic();
    int w;
    do_transfer("basic", 4'b0001, 32'h0000_00A5, 0, 1, 1'b0, w);
  endtask

  task automatic test_idle_ignore();
    req          = '0;
    bus_received = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({grant, bus_sent, done, timeout_err, busy} !== '0) begin
        n_fail++;
        $display("FAIL idle_ack cycle %0d: got %h expected 0", i,
                 {grant, bus_sent, done, timeout_err, busy});
      end
    end
    bus_received = 1'b0;
  endtask

  task automatic test_round_robin();
    int w;
    apply_reset();
    for (int i = 0; i < NREQ + 1; i++)
      do_transfer("round_robin", 4'b1111, rand_data(), 0, 1, 1'b0, w);
  endtask

  task automatic test_timeout();
    int w;
    do_transfer("timeout", 4'b0100, rand_data(), TIMEOUT + 4, 1, 1'b0, w);
    // Pointer must now sit on master 3, ahead of master 0.
    do_transfer("timeout_next", 4'b1001, rand_data(), 2, 1, 1'b0, w);
  endtask

  task automatic test_ack_at_limit();
    int w;
    do_transfer("ack_at_limit", 4'b0110, rand_data(), TIMEOUT - 1, 1, 1'b0, w);
  endtask

  task automatic test_hold_ack();
    int w;
    do_transfer("hold_ack", 4'b1111, rand_data(), 1, 6, 1'b1, w);
  endtask

  task automatic test_reset_mid();
    int w;
    do_transfer("rm_pre", 4'b0010, rand_data(), 0, 1, 1'b0, w);
    req      = 4'b0010;
    req_data = 32'h0000_5A00;
    step();
    n_tests++;
    if (grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL rm_grant: got %b expected 0010", grant);
    end
    step();
    step();
    reset = 1'b1;
    req   = 4'b1010;
    step();
    n_tests++;
    if (observed() !== '0) begin
      n_fail++;
      $display("FAIL rm_reset: got %h expected 0", observed());
    end
    reset     = 1'b0;
    model_ptr = 0;
    do_transfer("rm_regrant", 4'b1010, rand_data(), 1, 1, 1'b0, w);
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 40; i++) begin
      do_transfer("random", NREQ'($urandom_range(1, (1 << NREQ) - 1)), rand_data(),
                  $urandom_range(0, TIMEOUT + 3), $urandom_range(1, 3), 1'b1, w);
    end
  endtask

  initial begin
    reset        = 1'b1;
    req          = '0;
    req_data     = '0;
    bus_received = 1'b0;
    test_reset();
    test_basic();
    test_idle_ignore();
    test_round_robin();
    test_timeout();
    test_ack_at_limit();
    test_hold_ack();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
